// File: rtl/rice_bus_arbiter_if.sv
// ============================================================================
// Module   : rice_bus_arbiter_if
// Brief    : Two-master / one-slave rice core bus bundle. The slave modport is
//            the arbiter's view, the master modport is the environment's view.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rice_bus_arbiter_if #(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8
);
  logic [1:0]                    i_mst_request_valid;
  logic [1:0]                    o_mst_request_ready;
  logic [1:0][ADDRESS_WIDTH-1:0] i_mst_address;
  logic [1:0][STROBE_WIDTH-1:0]  i_mst_strobe;
  logic [1:0][DATA_WIDTH-1:0]    i_mst_write_data;
  logic [1:0]                    i_mst_response_ready;
  logic [1:0]                    o_mst_response_valid;
  logic [DATA_WIDTH-1:0]         o_mst_read_data;
  logic                          o_mst_error;

  logic                          o_slv_request_valid;
  logic [ADDRESS_WIDTH-1:0]      o_slv_address;
  logic [STROBE_WIDTH-1:0]       o_slv_strobe;
  logic [DATA_WIDTH-1:0]         o_slv_write_data;
  logic                          i_slv_request_ready;
  logic                          i_slv_response_valid;
  logic [DATA_WIDTH-1:0]         i_slv_read_data;
  logic                          i_slv_error;
  logic                          o_slv_response_ready;

  modport slave (
    input  i_mst_request_valid, i_mst_address, i_mst_strobe, i_mst_write_data,
    input  i_mst_response_ready,
    output o_mst_request_ready, o_mst_response_valid, o_mst_read_data, o_mst_error,
    output o_slv_request_valid, o_slv_address, o_slv_strobe, o_slv_write_data,
    input  i_slv_request_ready, i_slv_response_valid, i_slv_read_data, i_slv_error,
    output o_slv_response_ready
  );

  modport master (
    output i_mst_request_valid, i_mst_address, i_mst_strobe, i_mst_write_data,
    output i_mst_response_ready,
    input  o_mst_request_ready, o_mst_response_valid, o_mst_read_data, o_mst_error,
    input  o_slv_request_valid, o_slv_address, o_slv_strobe, o_slv_write_data,
    output i_slv_request_ready, i_slv_response_valid, i_slv_read_data, i_slv_error,
    input  o_slv_response_ready
  );
endinterface

`default_nettype wire

// File: rtl/rice_bus_arbiter.sv
// ============================================================================
// Module   : rice_bus_arbiter
// Brief    : Round-robin 2:1 request arbiter with stall lock; in-order responses
//            routed back through a FIFO of master IDs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rice_bus_arbiter #(
  parameter int ADDRESS_WIDTH   = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int STROBE_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  rice_bus_arbiter_if.slave  bus_if
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] C_LAST_PTR   = PTR_W'(MAX_OUTSTANDING - 1);

  logic                       r_prio_q,     r_prio_d;
  logic                       r_lock_q,     r_lock_d;
  logic                       r_lock_idx_q, r_lock_idx_d;
  logic [CNT_W-1:0]           r_count_q,    r_count_d;
  logic [PTR_W-1:0]           r_wr_ptr_q,   r_wr_ptr_d;
  logic [PTR_W-1:0]           r_rd_ptr_q,   r_rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] r_fifo_q;

  logic                       w_grant_vld;
  logic                       w_grant_idx;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_req_valid;
  logic                       w_req_ready;
  logic                       w_accept;
  logic                       w_stall;
  logic                       w_head;
  logic                       w_rsp_ready;
  logic                       w_pop;
  logic [ADDRESS_WIDTH-1:0]   w_slv_address;
  logic [STROBE_WIDTH-1:0]    w_slv_strobe;
  logic [DATA_WIDTH-1:0]      w_slv_write_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == C_LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = 1'b0;
    if (r_lock_q) begin
      w_grant_vld = 1'b1;
      w_grant_idx = r_lock_idx_q;
    end else begin
      case (bus_if.i_mst_request_valid)
        2'b01:   begin w_grant_vld = 1'b1; w_grant_idx = 1'b0;     end
        2'b10:   begin w_grant_vld = 1'b1; w_grant_idx = 1'b1;     end
        2'b11:   begin w_grant_vld = 1'b1; w_grant_idx = r_prio_q; end
        default: begin w_grant_vld = 1'b0; w_grant_idx = 1'b0;     end
      endcase
    end
  end

  assign w_full  = (r_count_q == C_FULL_COUNT);
  assign w_empty = (r_count_q == '0);

  // Handshake outputs are gated by reset so they read 0 while it is held,
  // even with masters still asserting valid.
  assign w_req_valid = i_rst_n & w_grant_vld & bus_if.i_mst_request_valid[w_grant_idx] & ~w_full;
  assign w_req_ready = i_rst_n & w_grant_vld & bus_if.i_slv_request_ready & ~w_full;
  assign w_accept    = w_req_valid & bus_if.i_slv_request_ready;
  assign w_stall     = w_req_valid & ~bus_if.i_slv_request_ready;

  assign w_slv_address    = bus_if.i_mst_address[w_grant_idx];
  assign w_slv_strobe     = bus_if.i_mst_strobe[w_grant_idx];
  assign w_slv_write_data = bus_if.i_mst_write_data[w_grant_idx];

  assign bus_if.o_slv_request_valid = w_req_valid;
  assign bus_if.o_slv_address       = w_slv_address;
  assign bus_if.o_slv_strobe        = w_slv_strobe;
  assign bus_if.o_slv_write_data    = w_slv_write_data;
  assign bus_if.o_mst_request_ready = w_req_ready ? (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;

  assign w_head      = r_fifo_q[r_rd_ptr_q];
  assign w_rsp_ready = ~w_empty & bus_if.i_mst_response_ready[w_head];
  assign w_pop       = bus_if.i_slv_response_valid & w_rsp_ready;

  assign bus_if.o_slv_response_ready = w_rsp_ready;
  assign bus_if.o_mst_response_valid = (~w_empty & bus_if.i_slv_response_valid)
                                       ? (w_head ? 2'b10 : 2'b01) : 2'b00;
  assign bus_if.o_mst_read_data      = bus_if.i_slv_read_data;
  assign bus_if.o_mst_error          = bus_if.i_slv_error;

  always_comb begin
    r_prio_d     = r_prio_q;
    r_lock_d     = r_lock_q;
    r_lock_idx_d = r_lock_idx_q;
    r_count_d    = r_count_q;
    r_wr_ptr_d   = r_wr_ptr_q;
    r_rd_ptr_d   = r_rd_ptr_q;

    if (w_accept) begin
      r_prio_d   = ~w_grant_idx;
      r_lock_d   = 1'b0;
      r_wr_ptr_d = ptr_inc(r_wr_ptr_q);
    end else if (w_stall) begin
      r_lock_d     = 1'b1;
      r_lock_idx_d = w_grant_idx;
    end

    if (w_pop) begin
      r_rd_ptr_d = ptr_inc(r_rd_ptr_q);
    end

    case ({w_accept, w_pop})
      2'b10:   r_count_d = r_count_q + 1'b1;
      2'b01:   r_count_d = r_count_q - 1'b1;
      default: r_count_d = r_count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio_q     <= 1'b0;
      r_lock_q     <= 1'b0;
      r_lock_idx_q <= 1'b0;
      r_count_q    <= '0;
      r_wr_ptr_q   <= '0;
      r_rd_ptr_q   <= '0;
    end else begin
      r_prio_q     <= r_prio_d;
      r_lock_q     <= r_lock_d;
      r_lock_idx_q <= r_lock_idx_d;
      r_count_q    <= r_count_d;
      r_wr_ptr_q   <= r_wr_ptr_d;
      r_rd_ptr_q   <= r_rd_ptr_d;
    end
  end

  // ID storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_fifo_q[r_wr_ptr_q] <= w_grant_idx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rice_bus_arbiter.sv
// ============================================================================
// Module   : tb_rice_bus_arbiter
// Brief    : Scoreboard bench for rice_bus_arbiter with directed vectors.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rice_bus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rice_bus_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW)) bus_if ();

  rice_bus_arbiter #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .STROBE_WIDTH   (SW),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus_if (bus_if)
  );

  typedef struct {
    int unsigned   mst;
    logic [AW-1:0] addr;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    int unsigned   mst;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input int unsigned m);
    return (m == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mst(input int m, input logic v, input logic [AW-1:0] a,
                           input logic [SW-1:0] s, input logic [DW-1:0] d);
    bus_if.i_mst_request_valid[m] = v;
    bus_if.i_mst_address[m]       = a;
    bus_if.i_mst_strobe[m]        = s;
    bus_if.i_mst_write_data[m]    = d;
  endtask

  task automatic slv_rsp(input logic v, input logic [DW-1:0] d, input logic e);
    bus_if.i_slv_response_valid = v;
    bus_if.i_slv_read_data      = d;
    bus_if.i_slv_error          = e;
  endtask

  task automatic expect_req(input int unsigned m, input logic [AW-1:0] a,
                            input logic [SW-1:0] s, input logic [DW-1:0] d);
    req_t r;
    r.mst = m; r.addr = a; r.strb = s; r.wdata = d;
    exp_req_q.push_back(r);
  endtask

  task automatic expect_rsp(input int unsigned m, input logic [DW-1:0] d, input logic e);
    rsp_t r;
    r.mst = m; r.data = d; r.err = e;
    exp_rsp_q.push_back(r);
  endtask

  // Monitor: compares every completed handshake against the scoreboard head.
  initial begin
    req_t er;
    rsp_t es;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus_if.o_slv_request_valid === 1'b1 && bus_if.i_slv_request_ready === 1'b1) begin
          if (exp_req_q.size() == 0) begin
            check("req_unexpected", 64'(bus_if.o_slv_address), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            er = exp_req_q.pop_front();
            check("req_addr",  64'(bus_if.o_slv_address),    64'(er.addr));
            check("req_strb",  64'(bus_if.o_slv_strobe),     64'(er.strb));
            check("req_wdata", 64'(bus_if.o_slv_write_data), 64'(er.wdata));
            check("req_ready_onehot", 64'(bus_if.o_mst_request_ready), 64'(onehot(er.mst)));
          end
        end
        if (bus_if.i_slv_response_valid === 1'b1 && bus_if.o_slv_response_ready === 1'b1) begin
          if (exp_rsp_q.size() == 0) begin
            check("rsp_unexpected", 64'(bus_if.o_mst_response_valid), 64'h0);
          end else begin
            es = exp_rsp_q.pop_front();
            check("rsp_valid_onehot", 64'(bus_if.o_mst_response_valid), 64'(onehot(es.mst)));
            check("rsp_data", 64'(bus_if.o_mst_read_data), 64'(es.data));
            check("rsp_err",  64'(bus_if.o_mst_error),     64'(es.err));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every handshake input asserted: outputs must still be 0.
    rst_n = 1'b0;
    drive_mst(0, 1'b1, 64'h1234, 8'h00, 64'h0);
    drive_mst(1, 1'b1, 64'h5678, 8'h00, 64'h0);
    bus_if.i_slv_request_ready  = 1'b1;
    bus_if.i_mst_response_ready = 2'b11;
    slv_rsp(1'b1, 64'h0, 1'b0);
    #2;
    check("rst_slv_req_valid", 64'(bus_if.o_slv_request_valid),  64'h0);
    check("rst_mst_req_ready", 64'(bus_if.o_mst_request_ready),  64'h0);
    check("rst_mst_rsp_valid", 64'(bus_if.o_mst_response_valid), 64'h0);
    check("rst_slv_rsp_ready", 64'(bus_if.o_slv_response_ready), 64'h0);
    check("rst_addr_mux",      64'(bus_if.o_slv_address),        64'h1234);
    drive_mst(0, 1'b0, 64'h0, 8'h00, 64'h0);
    drive_mst(1, 1'b0, 64'h0, 8'h00, 64'h0);
    bus_if.i_slv_request_ready  = 1'b0;
    bus_if.i_mst_response_ready = 2'b00;
    slv_rsp(1'b0, 64'h0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Contention: both valid, slave always ready, responses one cycle later.
    bus_if.i_slv_request_ready  = 1'b1;
    bus_if.i_mst_response_ready = 2'b11;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        drive_mst(0, 1'b1, 64'h2000, 8'h00, 64'h0);
        drive_mst(1, 1'b1, 64'h3000, 8'hFF, 64'h1111);
        if (i % 2 == 0) expect_req(0, 64'h2000, 8'h00, 64'h0);
        else            expect_req(1, 64'h3000, 8'hFF, 64'h1111);
      end else begin
        drive_mst(0, 1'b0, 64'h0, 8'h00, 64'h0);
        drive_mst(1, 1'b0, 64'h0, 8'h00, 64'h0);
      end
      if (i >= 1) begin
        slv_rsp(1'b1, 64'(64'hA0 + i), 1'b0);
        expect_rsp(unsigned'((i - 1) % 2), 64'(64'hA0 + i), 1'b0);
      end
      step();
    end
    slv_rsp(1'b0, 64'h0, 1'b0);

    // Single read from M0.
    drive_mst(0, 1'b1, 64'h1000, 8'h00, 64'h0);
    expect_req(0, 64'h1000, 8'h00, 64'h0);
    #1;
    check("rd_same_cycle_valid", 64'(bus_if.o_slv_request_valid), 64'h1);
    check("rd_same_cycle_addr",  64'(bus_if.o_slv_address),       64'h1000);
    step();
    drive_mst(0, 1'b0, 64'h0, 8'h00, 64'h0);
    slv_rsp(1'b1, 64'hDEAD_BEEF, 1'b0);
    expect_rsp(0, 64'hDEAD_BEEF, 1'b0);
    #1;
    check("rd_rsp_ready", 64'(bus_if.o_slv_response_ready), 64'h1);
    step();
    check("rd_empty_rsp_ready", 64'(bus_if.o_slv_response_ready), 64'h0);
    check("rd_empty_rsp_valid", 64'(bus_if.o_mst_response_valid), 64'h0);
    slv_rsp(1'b0, 64'h0, 1'b0);

    // Stall lock: prio now points at M1.
    bus_if.i_slv_request_ready = 1'b0;
    drive_mst(1, 1'b1, 64'h5000, 8'h0F, 64'h55);
    #1;
    check("stall_c0_valid", 64'(bus_if.o_slv_request_valid), 64'h1);
    check("stall_c0_addr",  64'(bus_if.o_slv_address),       64'h5000);
    check("stall_c0_ready", 64'(bus_if.o_mst_request_ready), 64'h0);
    step();
    drive_mst(0, 1'b1, 64'h4000, 8'h00, 64'h0);
    #1;
    check("stall_c1_addr", 64'(bus_if.o_slv_address), 64'h5000);
    step();
    #1;
    check("stall_c2_addr", 64'(bus_if.o_slv_address), 64'h5000);
    step();
    bus_if.i_slv_request_ready = 1'b1;
    expect_req(1, 64'h5000, 8'h0F, 64'h55);
    step();
    drive_mst(1, 1'b1, 64'h5008, 8'h00, 64'h0);
    expect_req(0, 64'h4000, 8'h00, 64'h0);
    #1;
    check("after_stall_grant", 64'(bus_if.o_mst_request_ready), 64'h1);
    step();

    // FIFO full: two outstanding (M1 then M0), M1 waiting.
    drive_mst(0, 1'b0, 64'h0, 8'h00, 64'h0);
    #1;
    check("full_no_valid", 64'(bus_if.o_slv_request_valid), 64'h0);
    check("full_no_ready", 64'(bus_if.o_mst_request_ready), 64'h0);
    step();
    slv_rsp(1'b1, 64'h11, 1'b0);
    expect_rsp(1, 64'h11, 1'b0);
    #1;
    check("full_no_bypass", 64'(bus_if.o_slv_request_valid), 64'h0);
    step();
    slv_rsp(1'b1, 64'h22, 1'b1);
    expect_rsp(0, 64'h22, 1'b1);
    expect_req(1, 64'h5008, 8'h00, 64'h0);
    #1;
    check("full_relieved", 64'(bus_if.o_slv_request_valid), 64'h1);
    step();
    drive_mst(1, 1'b0, 64'h0, 8'h00, 64'h0);
    slv_rsp(1'b1, 64'h33, 1'b0);
    expect_rsp(1, 64'h33, 1'b0);
    step();
    slv_rsp(1'b0, 64'h0, 1'b0);

    // Response backpressure on head M0.
    drive_mst(0, 1'b1, 64'h6000, 8'h00, 64'h0);
    expect_req(0, 64'h6000, 8'h00, 64'h0);
    step();
    drive_mst(0, 1'b0, 64'h0, 8'h00, 64'h0);
    slv_rsp(1'b1, 64'h44, 1'b1);
    bus_if.i_mst_response_ready = 2'b10;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("bp_rsp_ready", 64'(bus_if.o_slv_response_ready), 64'h0);
      check("bp_rsp_valid", 64'(bus_if.o_mst_response_valid), 64'h1);
      step();
    end
    bus_if.i_mst_response_ready = 2'b11;
    expect_rsp(0, 64'h44, 1'b1);
    step();
    #1;
    check("bp_empty_rsp_ready", 64'(bus_if.o_slv_response_ready), 64'h0);
    slv_rsp(1'b0, 64'h0, 1'b0);

    // Reset mid-operation: one outstanding, lock held on M1, prio at M1.
    drive_mst(0, 1'b1, 64'h7000, 8'h00, 64'h0);
    expect_req(0, 64'h7000, 8'h00, 64'h0);
    step();
    drive_mst(0, 1'b0, 64'h0, 8'h00, 64'h0);
    drive_mst(1, 1'b1, 64'h7100, 8'h00, 64'h0);
    bus_if.i_slv_request_ready = 1'b0;
    step();
    drive_mst(0, 1'b1, 64'h7000, 8'h00, 64'h0);
    slv_rsp(1'b1, 64'h99, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_slv_req_valid", 64'(bus_if.o_slv_request_valid),  64'h0);
    check("midrst_mst_req_ready", 64'(bus_if.o_mst_request_ready),  64'h0);
    check("midrst_mst_rsp_valid", 64'(bus_if.o_mst_response_valid), 64'h0);
    check("midrst_slv_rsp_ready", 64'(bus_if.o_slv_response_ready), 64'h0);
    step();
    rst_n = 1'b1;
    bus_if.i_slv_request_ready = 1'b1;
    expect_req(0, 64'h7000, 8'h00, 64'h0);
    #1;
    check("postrst_grant_m0",  64'(bus_if.o_mst_request_ready),  64'h1);
    check("postrst_empty",     64'(bus_if.o_slv_response_ready), 64'h0);
    step();
    drive_mst(0, 1'b0, 64'h0, 8'h00, 64'h0);
    drive_mst(1, 1'b0, 64'h0, 8'h00, 64'h0);
    slv_rsp(1'b0, 64'h0, 1'b0);
    bus_if.i_slv_request_ready = 1'b0;
    step();
    step();

    check("req_scoreboard_drained", 64'(exp_req_q.size()), 64'h0);
    check("rsp_scoreboard_drained", 64'(exp_rsp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
